serial_add_ctrl: RTL and testbench

//  Bit-serial add/subtract sequencer around one fulladder cell (ports sum, carry, a, b, cin).

---
 rtl/serial_add_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full adder, one operand bit pair per cycle, LSB first.
// Latency: accept on edge 0, done pulses in the cycle after edge WIDTH, ready again after edge WIDTH+1.
// Backpressure: start is honoured only while ready=1; requests while busy are dropped, never queued.

module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  // Plain 1-bit full adder cell
  always_comb begin
    sum   = a ^ b ^ cin;
    carry = (a & b) | (a & cin) | (b & cin);
  end

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_r;
  logic [CW-1:0]    cnt;
  logic             c;

  logic             fa_sum;
  logic             fa_carry;

  // sh_r[0] is the oldest sum bit and simply falls off the end of the shift
  logic             unused_sh_r_lsb;
  assign unused_sh_r_lsb = sh_r[0];

  fulladder u_fa (
    .a     (sh_a[0]),
    .b     (sh_b[0]),
    .cin   (c),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Sequencer: operand load, per-bit shift/carry update, result capture and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sh_a      <= '0;
      sh_b      <= '0;
      sh_r      <= '0;
      cnt       <= '0;
      c         <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with 1
            sh_a  <= op_a;
            sh_b  <= sub ? ~op_b : op_b;
            c     <= sub;
            cnt   <= '0;
            state <= S_RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end

        S_RUN: begin
          if (abort) begin
            // Cancel wins over the last-bit capture; previous outputs are kept
            state <= S_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else begin
            sh_r <= {fa_sum, sh_r[WIDTH-1:1]};
            sh_a <= {1'b0, sh_a[WIDTH-1:1]};
            sh_b <= {1'b0, sh_b[WIDTH-1:1]};
            c    <= fa_carry;
            cnt  <= cnt + CW'(1);
            if (cnt == LAST_BIT) begin
              // Overflow: carry into the MSB differs from carry out of it
              result    <= {fa_sum, sh_r[WIDTH-1:1]};
              carry_out <= fa_carry;
              overflow  <= c ^ fa_carry;
              state     <= S_DONE;
              done      <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end

        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8.
// Checks results, flags, done timing relative to the accept edge, abort and async reset.
// Inputs are driven on the falling edge, outputs sampled 1 time unit after the rising edge.

module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       abort;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry_out;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .abort     (abort),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op, scramble the operand inputs after acceptance, observe 12 edges.
  task automatic exec_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                         output int done_edge, output int pulses,
                         output logic rdy8, output logic rdy9, output logic busy1);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a = ~a; op_b = a ^ b; sub = ~s;
    done_edge = -1;
    pulses = 0;
    rdy8 = 1'bx; rdy9 = 1'bx; busy1 = 1'bx;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        pulses++;
        if (done_edge < 0) done_edge = k;
      end
      if (k == 1) busy1 = busy;
      if (k == 8) rdy8 = ready;
      if (k == 9) rdy9 = ready;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b1)    begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 8'h00)  begin errors++; $display("FAIL reset_result: got %h expected 00", result); end
    checks++; if (carry_out !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got c=%b v=%b expected c=0 v=0", carry_out, overflow);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add;
    int de, np; logic r8, r9, b1;
    exec_op(8'h0F, 8'h01, 1'b0, de, np, r8, r9, b1);
    checks++; if (b1 !== 1'b1)  begin errors++; $display("FAIL add_busy: got %b expected 1", b1); end
    checks++; if (de !== 8)     begin errors++; $display("FAIL add_done_edge: got %0d expected 8", de); end
    checks++; if (np !== 1)     begin errors++; $display("FAIL add_done_pulses: got %0d expected 1", np); end
    checks++; if (r8 !== 1'b0)  begin errors++; $display("FAIL add_ready_e8: got %b expected 0", r8); end
    checks++; if (r9 !== 1'b1)  begin errors++; $display("FAIL add_ready_e9: got %b expected 1", r9); end
    checks++; if (result !== 8'h10) begin errors++; $display("FAIL add_result: got %h expected 10", result); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL add_carry: got %b expected 0", carry_out); end
    checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL add_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_abort;
    int np;
    @(negedge clk);
    op_a = 8'h22; op_b = 8'h11; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", ready); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    np = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) np++;
    end
    checks++; if (np !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", np); end
    checks++; if (result !== 8'h10) begin errors++; $display("FAIL abort_result_hold: got %h expected 10", result); end
    begin
      int de; logic r8, r9, b1;
      exec_op(8'h22, 8'h11, 1'b0, de, np, r8, r9, b1);
      checks++; if (de !== 8) begin errors++; $display("FAIL abort_next_done_edge: got %0d expected 8", de); end
      checks++; if (result !== 8'h33) begin errors++; $display("FAIL abort_next_result: got %h expected 33", result); end
    end
  endtask

  task automatic test_carry_ovf;
    int de, np; logic r8, r9, b1;
    exec_op(8'hFF, 8'h01, 1'b0, de, np, r8, r9, b1);
    checks++; if (de !== 8 || np !== 1) begin errors++; $display("FAIL wrap_done: got edge %0d pulses %0d expected edge 8 pulses 1", de, np); end
    checks++; if ({result, carry_out, overflow} !== {8'h00, 1'b1, 1'b0}) begin
      errors++; $display("FAIL wrap_out: got %h c=%b v=%b expected 00 c=1 v=0", result, carry_out, overflow);
    end
    exec_op(8'h7F, 8'h01, 1'b0, de, np, r8, r9, b1);
    checks++; if (de !== 8 || r9 !== 1'b1) begin errors++; $display("FAIL povf_timing: got edge %0d ready9 %b expected edge 8 ready9 1", de, r9); end
    checks++; if ({result, carry_out, overflow} !== {8'h80, 1'b0, 1'b1}) begin
      errors++; $display("FAIL povf_out: got %h c=%b v=%b expected 80 c=0 v=1", result, carry_out, overflow);
    end
  endtask

  task automatic test_sub;
    int de, np; logic r8, r9, b1;
    exec_op(8'h05, 8'h07, 1'b1, de, np, r8, r9, b1);
    checks++; if (de !== 8 || np !== 1) begin errors++; $display("FAIL sub_neg_done: got edge %0d pulses %0d expected edge 8 pulses 1", de, np); end
    checks++; if ({result, carry_out, overflow} !== {8'hFE, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sub_neg_out: got %h c=%b v=%b expected FE c=0 v=0", result, carry_out, overflow);
    end
    exec_op(8'h80, 8'h01, 1'b1, de, np, r8, r9, b1);
    checks++; if (de !== 8) begin errors++; $display("FAIL sub_ovf_done: got edge %0d expected 8", de); end
    checks++; if ({result, carry_out, overflow} !== {8'h7F, 1'b1, 1'b1}) begin
      errors++; $display("FAIL sub_ovf_out: got %h c=%b v=%b expected 7F c=1 v=1", result, carry_out, overflow);
    end
  endtask

  task automatic test_back_to_back;
    int de, np; logic r9;
    @(negedge clk);
    op_a = 8'h30; op_b = 8'h03; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    de = -1; np = 0; r9 = 1'bx;
    // Keep hammering start with other operands through RUN and DONE (edges 1..9)
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      op_a = 8'hA0 ^ 8'(k); op_b = 8'h55; sub = k[0]; start = 1'b1;
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        np++;
        if (de < 0) de = k;
      end
      if (k == 9) r9 = ready;
    end
    @(negedge clk);
    start = 1'b0;
    checks++; if (de !== 8 || np !== 1) begin errors++; $display("FAIL ignore_done: got edge %0d pulses %0d expected edge 8 pulses 1", de, np); end
    checks++; if (result !== 8'h33) begin errors++; $display("FAIL ignore_result: got %h expected 33", result); end
    checks++; if (r9 !== 1'b1) begin errors++; $display("FAIL ignore_ready_e9: got %b expected 1", r9); end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_not_queued: got busy %b expected 0", busy); end
    begin
      logic r8, b1;
      exec_op(8'h01, 8'h02, 1'b0, de, np, r8, r9, b1);
      checks++; if (de !== 8 || result !== 8'h03) begin
        errors++; $display("FAIL ignore_next: got edge %0d result %h expected edge 8 result 03", de, result);
      end
    end
  endtask

  task automatic test_async_reset;
    int de, np; logic r8, r9, b1;
    @(negedge clk);
    op_a = 8'h55; op_b = 8'h22; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL areset_status: got r=%b b=%b d=%b expected r=1 b=0 d=0", ready, busy, done);
    end
    checks++; if ({result, carry_out, overflow} !== 10'h000) begin
      errors++; $display("FAIL areset_out: got %h c=%b v=%b expected 00 c=0 v=0", result, carry_out, overflow);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exec_op(8'h01, 8'h01, 1'b0, de, np, r8, r9, b1);
    checks++; if (de !== 8 || np !== 1) begin errors++; $display("FAIL areset_next_done: got edge %0d pulses %0d expected edge 8 pulses 1", de, np); end
    checks++; if (result !== 8'h02) begin errors++; $display("FAIL areset_next_result: got %h expected 02", result); end
  endtask

  initial begin
    start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0; abort = 1'b0; rst_n = 1'b1;
    test_reset();
    test_add();
    test_abort();
    test_carry_ovf();
    test_sub();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
